crc8_framer: RTL and testbench
==============================

Name: crc8_framer

Overview:
Upstream companion to crc8: takes a byte-stream frame with valid/ready/last, forwards each payload byte downstream, and appends the frame's CRC-8 as a final trailer byte. Drives a crc8 instance's data_i/data_valid_i and per-frame clear, and reads its crc_o. Sits between the packet source and the serial/link transmitter.

Parameters:
CRC_LATENCY, 1, cycles from crc_valid_o asserted to crc_i reflecting that byte (1..4)
STATS_WIDTH, 16, width of frame counter (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
s_data_i  in  8  upstream payload byte
s_valid_i  in  1  upstream byte valid
s_last_i  in  1  marks final payload byte of frame
s_ready_o  out  1  framer accepts byte this cycle
m_data_o  out  8  downstream byte (payload or CRC trailer)
m_valid_o  out  1  downstream byte valid
m_last_o  out  1  high only on CRC trailer byte
m_ready_i  in  1  downstream accepts byte
crc_data_o  out  8  byte to crc8 data_i
crc_valid_o  out  1  to crc8 data_valid_i
crc_clear_o  out  1  to crc8 rst_i; restarts CRC (init 0x00)
crc_i  in  8  crc8 crc_o

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Reset values: m_valid_o=0, m_last_o=0, m_data_o=0x00, s_ready_o=0, crc_valid_o=0; crc_clear_o=1 while rst_i high. State -> CLEAR.
- States: CLEAR, DATA, WAIT_CRC, SEND_CRC.
- CLEAR: crc_clear_o=1 for exactly one cycle; s_ready_o=0; -> DATA.
- DATA: s_ready_o = !m_valid_o || m_ready_i. Accept = s_valid_i && s_ready_o.
- On accept: m_data_o<=s_data_i, m_valid_o<=1, m_last_o<=0. crc_data_o=s_data_i and crc_valid_o=1 combinationally in the same cycle.
- If the accepted byte has s_last_i=1: load latency counter with CRC_LATENCY and go to WAIT_CRC.
- Output register holds when m_valid_o && !m_ready_i; it clears m_valid_o on m_ready_i with no new load.
- WAIT_CRC: s_ready_o=0; decrement counter; at 0 -> SEND_CRC. Payload byte may drain meanwhile.
- SEND_CRC: when !m_valid_o || m_ready_i, load m_data_o<=crc_i, m_valid_o<=1, m_last_o<=1 -> CLEAR. crc_i is sampled at load.
- Full-throughput payload: 1 byte/cycle with m_ready_i held high. Per-frame overhead: CRC_LATENCY+2 cycles.
- Single-byte frame (valid and last together) is legal. Zero-length frames are unsupported: there is no way to express them.
- Backpressure during SEND_CRC stalls in SEND_CRC; crc_i must stay stable, since crc8 gets no further valid.
- Reset mid-frame: frame is discarded, output slot is emptied, CRC is cleared via CLEAR; no trailer is emitted.
- crc_valid_o is never asserted outside DATA.

Optional Feature:
CRC8_FRAMER_STATS_EN
- Defined: extra output frames_o [STATS_WIDTH-1:0], reset 0. Increments when the trailer byte handshakes (m_valid_o && m_ready_i && m_last_o). Wraps from all-ones to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package crc8_pkg: POLYNOMIAL default 8'h07, CRC_INIT 8'h00, and the framer state enum typedef.
- One natural sub-module: crc8_latency_counter (loadable down-counter, done flag).
- The crc8 core itself is instantiated beside the framer at the top level, not inside it; rst_i | crc_clear_o feeds crc8 rst_i.

Test Plan:
- Frame ASCII "123456789" (0x31..0x39), last on 0x39, m_ready_i=1 -> output is those 9 bytes then 0xF4 with m_last_o=1 only on 0xF4.
- Single-byte frames 0x01 then 0xFF back-to-back -> 0x01,0x07(last) then 0xFF,0xF3(last). Proves the CRC is cleared between frames.
- Random m_ready_i (50%) on the 9-byte frame -> identical byte sequence with no drop or duplicate. m_data_o stays stable while m_valid_o && !m_ready_i.
- rst_i asserted after 4 bytes accepted, then frame 0x00 (last) -> no trailer for the aborted frame. Output is 0x00,0x00(last).
- CRC_LATENCY=3, frame 0x01 -> trailer 0x07 emitted; s_ready_o low for exactly CRC_LATENCY+2 cycles after last accept with m_ready_i=1.
- With CRC8_FRAMER_STATS_EN, STATS_WIDTH=2: send 5 frames -> frames_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/crc8_pkg.sv
// rtl/crc8_pkg.sv - CRC-8 constants, framer state type and byte-update helper
// Contents: POLYNOMIAL, CRC_INIT, framer_state_t, crc8_next()
package crc8_pkg;

    localparam logic [7:0] POLYNOMIAL = 8'h07;
    localparam logic [7:0] CRC_INIT   = 8'h00;

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_DATA     = 2'd1,
        ST_WAIT_CRC = 2'd2,
        ST_SEND_CRC = 2'd3
    } framer_state_t;

    // MSB-first, non-reflected CRC-8 update for one byte
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ POLYNOMIAL) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8.sv
// rtl/crc8.sv - registered CRC-8 core, one byte per cycle
// Ports: clk_i, rst_i (sync, active-high, loads CRC_INIT), data_i, data_valid_i, crc_o
module crc8
    import crc8_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic [7:0] crc_o
);

    logic [7:0] r_crc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_crc <= CRC_INIT;
        end else if (data_valid_i) begin
            r_crc <= crc8_next(r_crc, data_i);
        end
    end

    assign crc_o = r_crc;

endmodule

// File: rtl/crc8_framer_latency_counter.sv
// rtl/crc8_framer_latency_counter.sv - loadable down-counter timing the CRC settle window
// Ports: i_clk, i_rst, i_load, i_load_val, i_dec, o_done (high on the final counted cycle)
module crc8_latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Done while the count is at 1: this decrement takes it to zero, so the
    // owner leaves its wait state after exactly load_val counted cycles.
    assign o_done = (r_count <= WIDTH'(1));

endmodule

// File: rtl/crc8_framer.sv
// rtl/crc8_framer.sv - forwards a valid/ready/last byte frame and appends its CRC-8 trailer
// Ports: clk_i, rst_i; s_data_i/s_valid_i/s_last_i/s_ready_o upstream;
//        m_data_o/m_valid_o/m_last_o/m_ready_i downstream; crc_data_o/crc_valid_o/
//        crc_clear_o/crc_i to an external crc8 core; frames_o when CRC8_FRAMER_STATS_EN
// Optional feature macro: CRC8_FRAMER_STATS_EN
module crc8_framer
    import crc8_pkg::*;
#(
    parameter int CRC_LATENCY = 1
`ifdef CRC8_FRAMER_STATS_EN
    ,
    parameter int STATS_WIDTH = 16
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    output logic       m_last_o,
    input  logic       m_ready_i,
    output logic [7:0] crc_data_o,
    output logic       crc_valid_o,
    output logic       crc_clear_o,
    input  logic [7:0] crc_i
`ifdef CRC8_FRAMER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] frames_o
`endif
);

    localparam int COUNT_W = $clog2(CRC_LATENCY + 1);

    framer_state_t r_state;
    logic [7:0]    r_m_data;
    logic          r_m_valid;
    logic          r_m_last;

    logic w_out_free;
    logic w_accept;
    logic w_cnt_done;

    // The output slot can take a new byte when empty or when it drains this cycle
    assign w_out_free = !r_m_valid || m_ready_i;
    assign s_ready_o  = !rst_i && (r_state == ST_DATA) && w_out_free;
    assign w_accept   = s_valid_i && s_ready_o;

    // The CRC core sees the byte in the same cycle it is accepted
    assign crc_data_o  = s_data_i;
    assign crc_valid_o = w_accept;
    assign crc_clear_o = rst_i || (r_state == ST_CLEAR);

    crc8_latency_counter #(
        .WIDTH(COUNT_W)
    ) u_lat (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (w_accept && s_last_i),
        .i_load_val (COUNT_W'(CRC_LATENCY)),
        .i_dec      (r_state == ST_WAIT_CRC),
        .o_done     (w_cnt_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_CLEAR;
            r_m_data  <= 8'h00;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            // Drain by default; a load below overrides it in the same cycle
            if (r_m_valid && m_ready_i) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            case (r_state)
                ST_CLEAR: r_state <= ST_DATA;
                ST_DATA: begin
                    if (w_accept) begin
                        r_m_data  <= s_data_i;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                        if (s_last_i) r_state <= ST_WAIT_CRC;
                    end
                end
                ST_WAIT_CRC: begin
                    if (w_cnt_done) r_state <= ST_SEND_CRC;
                end
                ST_SEND_CRC: begin
                    if (w_out_free) begin
                        r_m_data  <= crc_i;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b1;
                        r_state   <= ST_CLEAR;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign m_data_o  = r_m_data;
    assign m_valid_o = r_m_valid;
    assign m_last_o  = r_m_last;

`ifdef CRC8_FRAMER_STATS_EN
    logic [STATS_WIDTH-1:0] r_frames;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frames <= '0;
        end else if (r_m_valid && m_ready_i && r_m_last) begin
            r_frames <= r_frames + 1'b1;
        end
    end

    assign frames_o = r_frames;
`endif

endmodule

// File: tb/tb_crc8_framer.sv
// tb/tb_crc8_framer.sv - self-checking bench for crc8_framer with an external crc8 core
module tb_crc8_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_ready;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_ready;
    logic [7:0] crc_data, crc_val;
    logic       crc_valid, crc_clear;

    logic [7:0] s_data2;
    logic       s_valid2, s_last2, s_ready2;
    logic [7:0] m_data2;
    logic       m_valid2, m_last2, m_ready2;
    logic [7:0] crc_data2, crc_val2;
    logic       crc_valid2, crc_clear2;

`ifdef CRC8_FRAMER_STATS_EN
    logic [1:0] frames;
    logic [1:0] frames2;
`endif

    always #5 clk = ~clk;

    crc8_framer #(
        .CRC_LATENCY(1)
`ifdef CRC8_FRAMER_STATS_EN
        , .STATS_WIDTH(2)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
        .crc_data_o(crc_data), .crc_valid_o(crc_valid), .crc_clear_o(crc_clear), .crc_i(crc_val)
`ifdef CRC8_FRAMER_STATS_EN
        , .frames_o(frames)
`endif
    );

    crc8 u_crc (.clk_i(clk), .rst_i(rst | crc_clear), .data_i(crc_data),
                .data_valid_i(crc_valid), .crc_o(crc_val));

    crc8_framer #(
        .CRC_LATENCY(3)
`ifdef CRC8_FRAMER_STATS_EN
        , .STATS_WIDTH(2)
`endif
    ) dut2 (
        .clk_i(clk), .rst_i(rst),
        .s_data_i(s_data2), .s_valid_i(s_valid2), .s_last_i(s_last2), .s_ready_o(s_ready2),
        .m_data_o(m_data2), .m_valid_o(m_valid2), .m_last_o(m_last2), .m_ready_i(m_ready2),
        .crc_data_o(crc_data2), .crc_valid_o(crc_valid2), .crc_clear_o(crc_clear2), .crc_i(crc_val2)
`ifdef CRC8_FRAMER_STATS_EN
        , .frames_o(frames2)
`endif
    );

    crc8 u_crc2 (.clk_i(clk), .rst_i(rst | crc_clear2), .data_i(crc_data2),
                 .data_valid_i(crc_valid2), .crc_o(crc_val2));

    typedef struct {
        int         len;
        logic [7:0] d[9];
        logic [7:0] crc;
    } frame_t;

    frame_t tbl[5];

    int n_checks = 0;
    int n_pass   = 0;
    int stall_viol = 0;

    logic [7:0] cap_d[$];
    logic       cap_l[$];
    logic       rand_bp  = 1'b0;
    logic       ready_fix = 1'b1;
    logic       stall_prev = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Downstream ready changes just after each edge
    always @(posedge clk) begin
        #1;
        m_ready = rand_bp ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    // Capture handshakes and verify the output holds while stalled
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (!m_valid || m_data !== held)) stall_viol++;
            stall_prev = m_valid && !m_ready;
            held = m_data;
            if (m_valid && m_ready) begin
                cap_d.push_back(m_data);
                cap_l.push_back(m_last);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int t;
        s_data = b; s_last = last; s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) check("accept_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic run_frame(input int idx);
        int t;
        int n;
        cap_d.delete();
        cap_l.delete();
        n = tbl[idx].len;
        for (int b = 0; b < n; b++) send_byte(tbl[idx].d[b], (b == n - 1));
        s_valid = 1'b0;
        s_last  = 1'b0;
        t = 0;
        while (cap_d.size() < n + 1 && t < 500) begin
            step();
            t++;
        end
        check($sformatf("f%0d_count", idx), cap_d.size(), n + 1);
        for (int k = 0; k <= n; k++) begin
            if (k < cap_d.size()) begin
                check($sformatf("f%0d_data%0d", idx, k), cap_d[k], (k < n) ? tbl[idx].d[k] : tbl[idx].crc);
                check($sformatf("f%0d_last%0d", idx, k), cap_l[k], (k == n));
            end
        end
    endtask

    initial begin
        int lows, t, nl;
        logic seen;
        logic [7:0] tr;

        tbl[0].len = 9; tbl[0].crc = 8'hF4;
        for (int i = 0; i < 9; i++) tbl[0].d[i] = 8'h31 + 8'(i);
        tbl[1].len = 1; tbl[1].d[0] = 8'h01; tbl[1].crc = 8'h07;
        tbl[2].len = 1; tbl[2].d[0] = 8'hFF; tbl[2].crc = 8'hF3;
        tbl[3].len = 1; tbl[3].d[0] = 8'h00; tbl[3].crc = 8'h00;
        tbl[4].len = 2; tbl[4].d[0] = 8'h01; tbl[4].d[1] = 8'h00; tbl[4].crc = 8'h15;

        rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        s_data2 = 8'h00; s_valid2 = 1'b0; s_last2 = 1'b0; m_ready2 = 1'b1;
        step();
        step();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_crc_valid", crc_valid, 1'b0);
        check("rst_crc_clear", crc_clear, 1'b1);
        rst = 1'b0;

        // Table frames at full rate; 0x01 then 0xFF proves per-frame CRC clear
        for (int i = 0; i < 5; i++) run_frame(i);

        // Random backpressure on the 9-byte frame
        rand_bp = 1'b1;
        run_frame(0);
        rand_bp = 1'b0;
        check("stall_stability", stall_viol, 0);

        // Reset in the middle of a frame: no trailer, output slot emptied
        cap_d.delete();
        cap_l.delete();
        for (int b = 0; b < 4; b++) send_byte(8'h31 + 8'(b), 1'b0);
        s_valid = 1'b0;
        step();
        nl = 0;
        foreach (cap_l[k]) if (cap_l[k]) nl++;
        check("abort_no_trailer", nl, 0);
        rst = 1'b1;
        step();
        check("abort_m_valid", m_valid, 1'b0);
        check("abort_crc_clear", crc_clear, 1'b1);
        rst = 1'b0;
        run_frame(3);

        // CRC_LATENCY=3 instance: trailer and ready-low window
        s_data2 = 8'h01; s_last2 = 1'b1; s_valid2 = 1'b1;
        t = 0;
        while (!s_ready2 && t < 50) begin
            step();
            t++;
        end
        step();
        s_valid2 = 1'b0; s_last2 = 1'b0;
        lows = 0; seen = 1'b0; tr = 8'h00; t = 0;
        while (!s_ready2 && t < 50) begin
            if (m_valid2 && m_last2) begin
                seen = 1'b1;
                tr = m_data2;
            end
            lows++;
            step();
            t++;
        end
        check("lat3_ready_low", lows, 5);
        check("lat3_trailer_seen", seen, 1'b1);
        check("lat3_trailer", tr, 8'h07);

`ifdef CRC8_FRAMER_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stats_rst", frames, 2'd0);
        for (int f = 0; f < 5; f++) begin
            logic [1:0] exp_f;
            run_frame(1);
            step();
            exp_f = 2'((f + 1) % 4);
            check($sformatf("stats_%0d", f), frames, exp_f);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
